// File: rtl/bilateral_pkg.sv
// Shared types and geometry for the bilateral filter front end: image size,
// window shape, pixel/window/column types and the fetch-stage state encoding.
package bilateral_pkg;

    localparam int IMG_W = 256;
    localparam int IMG_H = 256;
    localparam int K     = 5;
    localparam int R     = (K - 1) / 2;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int AW    = 16;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = AW - CW;

    typedef logic [7:0] pixel_t;
    typedef pixel_t [K*K-1:0] window_t;
    // One vertical slice of the buffered rows; index 0 is the oldest row.
    typedef pixel_t [K-2:0] column_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bilateral_window_gen_if.sv
// Pixel-memory port and window stream of the bilateral window generator.
// master = window generator side, slave = memory/downstream side.
interface bilateral_window_gen_if;
    import bilateral_pkg::*;

    logic              in_valid;
    logic [AW-1:0]     mem_addr;
    pixel_t            mem_data;
    // Window stream: win_valid, win_pix and win_addr stay constant until an
    // edge with win_valid && win_ready, which transfers exactly one window;
    // win_valid never depends combinationally on win_ready.
    logic              win_valid;
    logic              win_ready;
    window_t           win_pix;
    logic [AW-1:0]     win_addr;
    logic              done;

    modport master (
        input  in_valid, mem_data, win_ready,
        output mem_addr, win_valid, win_pix, win_addr, done
    );

    modport slave (
        output in_valid, mem_data, win_ready,
        input  mem_addr, win_valid, win_pix, win_addr, done
    );

endinterface

// File: rtl/bilateral_line_buf.sv
// K-1 rows of image history addressed by column; each push returns the column
// above the incoming pixel and shifts that column up by one row.
module bilateral_line_buf
    import bilateral_pkg::*;
(
    input  logic          clk,
    input  logic          push,
    input  logic [CW-1:0] col,
    input  pixel_t        pix,
    output column_t       taps
);

    column_t mem [IMG_W];

    assign taps = mem[col];

    // Contents are never cleared: every column is rewritten before it feeds a window.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[col] <= {pix, mem[col][K-2:1]};
        end
    end

endmodule

// File: rtl/bilateral_window_gen.sv
// Raster fetch of the image, KxK window assembly and handshake to the filter core.
// Optional BILAT_WIN_STALL_CNT_EN adds stall_cnt, the count of back-pressured cycles.
module bilateral_window_gen
    import bilateral_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    bilateral_window_gen_if.master bus,
`ifdef BILAT_WIN_STALL_CNT_EN
    output logic [31:0]            stall_cnt,
`endif
    output state_t                 dbg_state
);

    localparam logic [AW-1:0] PEN_ADDR = AW'(NPIX - 2);
    localparam logic [AW-1:0] CTR_OFS  = AW'(R * IMG_W + R);
    localparam logic [CW-1:0] EDGE_COL = CW'(K - 1);
    localparam logic [RW-1:0] EDGE_ROW = RW'(K - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] win_addr_q;
    window_t       win_q;
    logic          win_valid_q, win_valid_nxt;
    logic          last_taken;
    logic          advance, start, consume, issue, rewind, emit;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    column_t       taps;

    // The pixel arriving on mem_data always belongs to the address still on addr_q.
    assign col  = addr_q[CW-1:0];
    assign row  = addr_q[AW-1:CW];
    assign emit = (row >= EDGE_ROW) && (col >= EDGE_COL);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        consume   = 1'b0;
        issue     = 1'b0;
        rewind    = 1'b0;
        advance   = !win_valid_q || bus.win_ready;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_nxt = ST_FETCH;
                    start     = 1'b1;
                end
            end
            ST_FETCH: begin
                if (advance) begin
                    consume = 1'b1;
                    issue   = 1'b1;
                    if (addr_q == PEN_ADDR) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (advance) begin
                    if (!last_taken) consume   = 1'b1;
                    else             state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.in_valid) begin
                    state_nxt = ST_IDLE;
                    rewind    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        win_valid_nxt = consume ? emit : (win_valid_q && !bus.win_ready);
    end

    bilateral_line_buf u_line_buf (
        .clk  (clk),
        .push (consume),
        .col  (col),
        .pix  (bus.mem_data),
        .taps (taps)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            win_addr_q  <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            last_taken  <= 1'b0;
        end else begin
            win_valid_q <= win_valid_nxt;
            if (start || rewind) begin
                addr_q     <= '0;
                last_taken <= 1'b0;
            end else if (issue) begin
                addr_q <= addr_q + 1'b1;
            end else if (consume) begin
                last_taken <= 1'b1;
            end
            // New column enters on the right; rows 0..K-2 come from history.
            if (consume) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        win_q[r*K+c] <= win_q[r*K+c+1];
                    end
                end
                for (int r = 0; r < K - 1; r++) begin
                    win_q[r*K+K-1] <= taps[r];
                end
                win_q[K*K-1] <= bus.mem_data;
                if (emit) win_addr_q <= addr_q - CTR_OFS;
            end
        end
    end

`ifdef BILAT_WIN_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start) begin
            stall_cnt <= '0;
        end else if (win_valid_q && !bus.win_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

    assign bus.mem_addr  = addr_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_pix   = win_q;
    assign bus.win_addr  = win_addr_q;
    assign bus.done      = (state == ST_DONE);
    assign dbg_state     = state;

endmodule

// File: doc/bilateral_window_gen.md
# bilateral_window_gen

Front-end fetch stage of the bilateral filter. Reads a 256x256 8-bit image from the external pixel memory in raster order through an address/data port with one-cycle read latency. Buffers K-1 image rows and streams one KxK neighbourhood window per cycle, with its centre address, to the downstream bilateral filter core under a valid/ready handshake.

## Interface
- IMG_W, 256: image width in pixels (power of 2)
- IMG_H, 256: image height in pixels
- K, 5: window side (odd); radius R=(K-1)/2=2
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  run enable; level, held high for the whole frame
- mem_addr  out  16  pixel read address, raster index row*IMG_W+col
- mem_data  in  8  pixel at the mem_addr value driven in the previous cycle
- win_valid  out  1  window output valid
- win_ready  in  1  downstream accepts window
- win_pix  out  8*K*K  window; element (r,c) at bits [8*(r*K+c)+:8], r=0 top row, c=0 left column, centre (R,R)
- win_addr  out  16  raster address of window centre pixel
- done  out  1  frame complete

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: in_valid=1 -> FETCH; row/col counters cleared; mem_addr=0.
- FETCH: advance = !win_valid || win_ready. On advance: consume mem_data as pixel of previously issued address, push into line buffer and window shift register, increment mem_addr. When !advance: hold mem_addr, counters, window; memory keeps returning the same pixel, so nothing is lost.
- After address IMG_W*IMG_H-1 is issued -> DRAIN. DRAIN consumes the last pixel, then waits for the last window to be accepted -> DONE.
- DONE: done=1 held while in_valid=1; in_valid=0 -> IDLE, done=0 next cycle.
- Window emitted when consumed pixel (row,col) has row>=K-1 and col>=K-1; win_addr=(row-R)*IMG_W+(col-R). Columns 0..K-2 of each row refill the shift register (which still holds previous-row pixels) and emit no window.
- Windows per frame: (IMG_H-K+1)*(IMG_W-K+1) = 63504 by default; centres rows/cols R..IMG_W-1-R.
- in_valid dropping mid-frame is ignored until DONE.
- Reset value of every output 0; rst mid-frame -> IDLE next cycle, outputs 0. Line-buffer contents are not cleared; they are don't-care because they refill before use.

## Timing
- Start edge E0: in_valid sampled 1 in IDLE; mem_addr=0 after E0. Address n is driven after edge E0+n and consumed at edge E0+n+1 (no stalls).
- First window: pixel (4,4), n=1028, so win_valid rises after edge E0+1029.
- Throughput 1 window/cycle within a row; K-1=4 bubble cycles at each row start.
- win_pix/win_addr stable while win_valid && !win_ready.
- Unstalled frame: last window valid after E0+65536; done after the accepting edge.

## Configuration
- BILAT_WIN_STALL_CNT_EN defined: adds output stall_cnt[31:0], counting cycles with win_valid && !win_ready. Cleared at the start edge; saturates at all-ones; holds through DONE. Reset 0.
- Undefined: no port, no counter logic. Behaviour otherwise identical.

## Structure
- Shared package bilateral_pkg: IMG_W, IMG_H, K, R constants; pixel_t (8-bit); window_t (K*K pixel_t); state enum for IDLE/FETCH/DRAIN/DONE.
- One sub-module, bilateral_line_buf: K-1 rows of IMG_W pixels, column write/read with shared col index, outputs K-1 vertically aligned pixels per push. The top holds the FSM, counters and KxK shift register.

## Test plan
- Image pix(r,c)=(r+c)&0xFF, win_ready=1 -> first win_valid 1029 cycles after start edge; win_addr=0x0202; win_pix(0,0)=0, centre=4, (4,4)=8.
- Same image, win_ready=1 -> exactly 63504 windows with strictly ascending win_addr. Window after centre (2,253) is (3,2), following a 4-cycle gap. done rises after the last acceptance.
- win_ready=0 for 10 cycles mid-row -> win_pix, win_addr and mem_addr frozen. On release the stream continues with no window skipped or duplicated, checked against a golden window model.
- rst pulsed at cycle 30000 -> next cycle all outputs 0, state IDLE. Restart reproduces the first window exactly.
- Macro defined, win_ready random 50% -> stall_cnt equals bench-counted stall cycles; full window sequence unchanged.
- in_valid held high after done -> done stays 1 and mem_addr does not change. in_valid=0 -> done=0 next cycle; a new start begins again at mem_addr=0.
